// File: rtl/data_bus_if.sv
// Memory-stage data bus: byte address, store data/strobe and combinational load data.
interface data_bus_if;
  logic [31:0] memory_address;
  logic [31:0] memory_write_value;
  logic        memory_write_enable;
  logic [31:0] memory_read_value;

  modport master (
    output memory_address,
    output memory_write_value,
    output memory_write_enable,
    input  memory_read_value
  );

  modport slave (
    input  memory_address,
    input  memory_write_value,
    input  memory_write_enable,
    output memory_read_value
  );
endinterface

// File: rtl/data_bus.sv
// Data-side memory system: word RAM plus an I/O page (LEDs, switches, cycle counter, timer).
// Loads are combinational; stores and all register updates commit on the clock edge.
module data_bus #(
  parameter int unsigned RAM_WORDS = 1024,
  parameter logic [31:0] IO_BASE   = 32'hFFFF_0000
) (
  input  logic         clock,
  input  logic         reset,
  data_bus_if.slave    bus,
  input  logic [17:0]  SW,
  output logic [17:0]  LEDR,
  output logic         timer_irq
);

  localparam int unsigned AW = $clog2(RAM_WORDS);

  typedef enum logic [2:0] {
    IO_LED    = 3'd0,
    IO_SWITCH = 3'd1,
    IO_CYCLES = 3'd2,
    IO_RELOAD = 3'd3,
    IO_CTRL   = 3'd4,
    IO_COUNT  = 3'd5,
    IO_RSVD6  = 3'd6,
    IO_RSVD7  = 3'd7
  } io_reg_e;

  logic [31:0]   ram [RAM_WORDS];
  logic [17:0]   led;
  logic [17:0]   sw_meta;
  logic [17:0]   sw_sync;
  logic [31:0]   cycles;
  logic [31:0]   reload;
  logic [31:0]   count;
  logic          enable;
  logic          auto_reload;
  logic          expired;
  logic          irq_enable;

  logic          ram_hit;
  logic          io_hit;
  logic [AW-1:0] ram_idx;
  io_reg_e       io_sel;
  logic          wr_io;
  logic          wr_led;
  logic          wr_cycles;
  logic          wr_reload;
  logic          wr_ctrl;
  logic          timer_tick;
  logic          timer_fire;
  logic [31:0]   wdata;
  logic          unused_addr_lsbs;

  assign wdata            = bus.memory_write_value;
  assign ram_hit          = (bus.memory_address[31:AW+2] == '0);
  assign io_hit           = (bus.memory_address[31:5] == IO_BASE[31:5]);
  assign ram_idx          = bus.memory_address[AW+1:2];
  assign io_sel           = io_reg_e'(bus.memory_address[4:2]);
  assign unused_addr_lsbs = ^bus.memory_address[1:0];

  assign wr_io     = bus.memory_write_enable && io_hit;
  assign wr_led    = wr_io && (io_sel == IO_LED);
  assign wr_cycles = wr_io && (io_sel == IO_CYCLES);
  assign wr_reload = wr_io && (io_sel == IO_RELOAD);
  assign wr_ctrl   = wr_io && (io_sel == IO_CTRL);

  assign timer_tick = enable && (count != '0);
  assign timer_fire = timer_tick && (count == 32'd1);

  assign LEDR      = led;
  assign timer_irq = expired && irq_enable;

  always_ff @(posedge clock) begin
    if (bus.memory_write_enable && ram_hit) ram[ram_idx] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      led         <= '0;
      sw_meta     <= '0;
      sw_sync     <= '0;
      cycles      <= '0;
      reload      <= '0;
      count       <= '0;
      enable      <= 1'b0;
      auto_reload <= 1'b0;
      expired     <= 1'b0;
      irq_enable  <= 1'b0;
    end else begin
      sw_meta <= SW;
      sw_sync <= sw_meta;

      if (wr_led) led <= wdata[17:0];

      if (wr_cycles) cycles <= '0;
      else           cycles <= cycles + 32'd1;

      if (wr_reload) reload <= wdata;

      // A RELOAD store overrides both the decrement and the auto-reload.
      if (wr_reload)                       count <= wdata;
      else if (timer_fire && auto_reload)  count <= reload;
      else if (timer_tick)                 count <= count - 32'd1;

      if (wr_ctrl) begin
        enable      <= wdata[0];
        auto_reload <= wdata[1];
        irq_enable  <= wdata[3];
      end

      // Expiry wins over a same-cycle write-1-to-clear so no event is lost.
      if (timer_fire)                  expired <= 1'b1;
      else if (wr_ctrl && wdata[2])    expired <= 1'b0;
    end
  end

  always_comb begin
    bus.memory_read_value = '0;
    if (ram_hit) begin
      bus.memory_read_value = ram[ram_idx];
    end else if (io_hit) begin
      case (io_sel)
        IO_LED:    bus.memory_read_value = {14'b0, led};
        IO_SWITCH: bus.memory_read_value = {14'b0, sw_sync};
        IO_CYCLES: bus.memory_read_value = cycles;
        IO_RELOAD: bus.memory_read_value = reload;
        IO_CTRL:   bus.memory_read_value = {28'b0, irq_enable, expired, auto_reload, enable};
        IO_COUNT:  bus.memory_read_value = count;
        default:   bus.memory_read_value = '0;
      endcase
    end
  end

endmodule
